// File: rtl/nw_fill_ctrl.sv
// Needleman-Wunsch matrix-fill sequencer: walks cells row-major, feeds Max, stores traceback symbols.
// Optional watchdog on the Max handshake is enabled by defining NW_WATCHDOG_EN.
module nw_fill_ctrl #(
  parameter int N        = 8,
  parameter int W        = 9,
  parameter int MATCH    = 1,
  parameter int MISMATCH = -1,
  parameter int GAP      = -2
`ifdef NW_WATCHDOG_EN
  , parameter int WD_MAX = 15
`endif
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    err,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]    addr_a,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]    addr_b,
  input  logic [1:0]                              char_a,
  input  logic [1:0]                              char_b,
  output logic                                    value,
  output logic signed [W-1:0]                     diag,
  output logic signed [W-1:0]                     up,
  output logic signed [W-1:0]                     lx,
  input  logic signed [W-1:0]                     max_in,
  input  logic [2:0]                              symbol_in,
  input  logic                                    calculated,
  output logic                                    tb_we,
  output logic [((N > 1) ? $clog2(N*N) : 1)-1:0]  tb_addr,
  output logic [2:0]                              tb_sym,
  output logic signed [W-1:0]                     final_score
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (N > 1) ? $clog2(N*N) : 1;
  localparam int JW = $clog2(N+1);

  localparam logic signed [W-1:0] MATCH_S    = W'(MATCH);
  localparam logic signed [W-1:0] MISMATCH_S = W'(MISMATCH);
  localparam logic signed [W-1:0] GAP_S      = W'(GAP);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ISSUE, S_WAIT, S_STORE, S_ROWSTEP, S_DONE
  } state_t;

  // Saturating signed add: overflow shows up as a sign mismatch in the extra top bit.
  function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    logic signed [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1])
      sat_add = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      sat_add = s[W-1:0];
  endfunction

  state_t              state_q, state_d;
  logic [AW-1:0]       ai_q, ai_d, bj_q, bj_d;
  logic [JW-1:0]       init_q, init_d;
  logic signed [W-1:0] dsrc_q, dsrc_d, left_q, left_d;
  logic signed [W-1:0] diag_q, diag_d, up_q, up_d, lx_q, lx_d;
  logic signed [W-1:0] res_q, res_d, final_q, final_d;
  logic [2:0]          sym_q, sym_d;
`ifdef NW_WATCHDOG_EN
  localparam int WDW = $clog2(WD_MAX+1);
  logic                err_q, err_d;
  logic [WDW-1:0]      wd_q, wd_d;
`endif

  logic signed [W-1:0] row_buf [N+1];
  logic [JW-1:0]       jidx, init_prev;
  logic signed [W-1:0] row_j, row0, row_entry;

  assign jidx      = JW'(bj_q) + JW'(1);
  assign init_prev = (init_q == '0) ? '0 : init_q - 1'b1;
  assign row_j     = row_buf[jidx];
  assign row0      = row_buf[0];
  // row_buf[0] holds (i-1)*GAP at row entry, so one more GAP gives the new left boundary.
  assign row_entry = sat_add(row0, GAP_S);

  always_comb begin
    state_d = state_q;
    ai_d    = ai_q;
    bj_d    = bj_q;
    init_d  = init_q;
    dsrc_d  = dsrc_q;
    left_d  = left_q;
    diag_d  = diag_q;
    up_d    = up_q;
    lx_d    = lx_q;
    res_d   = res_q;
    sym_d   = sym_q;
    final_d = final_q;
`ifdef NW_WATCHDOG_EN
    err_d   = err_q;
    wd_d    = wd_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          init_d  = '0;
          ai_d    = '0;
          bj_d    = '0;
          final_d = '0;
`ifdef NW_WATCHDOG_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_INIT: begin
        init_d = init_q + 1'b1;
        if (init_q == JW'(N)) begin
          state_d = S_ISSUE;
          dsrc_d  = row0;
          left_d  = row_entry;
        end
      end
      S_ISSUE: begin
        diag_d  = sat_add(dsrc_q, (char_a == char_b) ? MATCH_S : MISMATCH_S);
        up_d    = sat_add(row_j, GAP_S);
        lx_d    = sat_add(left_q, GAP_S);
        state_d = S_WAIT;
`ifdef NW_WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      S_WAIT: begin
        if (calculated) begin
          res_d   = max_in;
          sym_d   = symbol_in;
          state_d = S_STORE;
        end
`ifdef NW_WATCHDOG_EN
        else if (wd_q == WDW'(WD_MAX-1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_STORE: begin
        dsrc_d = row_j;
        left_d = res_q;
        if (bj_q == AW'(N-1)) begin
          if (ai_q == AW'(N-1)) begin
            final_d = res_q;
            state_d = S_DONE;
          end else begin
            ai_d    = ai_q + 1'b1;
            bj_d    = '0;
            state_d = S_ROWSTEP;
          end
        end else begin
          bj_d    = bj_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ROWSTEP: begin
        dsrc_d  = row0;
        left_d  = row_entry;
        state_d = S_ISSUE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ai_q    <= '0;
      bj_q    <= '0;
      init_q  <= '0;
      dsrc_q  <= '0;
      left_q  <= '0;
      diag_q  <= '0;
      up_q    <= '0;
      lx_q    <= '0;
      res_q   <= '0;
      sym_q   <= '0;
      final_q <= '0;
`ifdef NW_WATCHDOG_EN
      err_q   <= 1'b0;
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      ai_q    <= ai_d;
      bj_q    <= bj_d;
      init_q  <= init_d;
      dsrc_q  <= dsrc_d;
      left_q  <= left_d;
      diag_q  <= diag_d;
      up_q    <= up_d;
      lx_q    <= lx_d;
      res_q   <= res_d;
      sym_q   <= sym_d;
      final_q <= final_d;
`ifdef NW_WATCHDOG_EN
      err_q   <= err_d;
      wd_q    <= wd_d;
`endif
    end
  end

  // One-row score buffer: boundary row during INIT, then overwritten cell by cell.
  always_ff @(posedge clk) begin
    case (state_q)
      S_INIT: begin
        row_buf[init_q] <= (init_q == '0) ? '0 : sat_add(row_buf[init_prev], GAP_S);
        if (init_q == JW'(N)) row_buf[0] <= row_entry;
      end
      S_ROWSTEP: row_buf[0] <= row_entry;
      S_STORE:   row_buf[jidx] <= res_q;
      default: ;
    endcase
  end

`ifdef NW_WATCHDOG_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign value       = (state_q == S_WAIT);
  assign tb_we       = (state_q == S_STORE);
  assign addr_a      = ai_q;
  assign addr_b      = bj_q;
  assign diag        = diag_q;
  assign up          = up_q;
  assign lx          = lx_q;
  assign tb_addr     = TW'(ai_q) * TW'(N) + TW'(bj_q);
  assign tb_sym      = sym_q;
  assign final_score = final_q;

endmodule

// File: tb/tb_nw_fill_ctrl.sv
// Directed bench for nw_fill_ctrl (N=4) with a behavioural Max of programmable latency.
module tb_nw_fill_ctrl;

  localparam int N  = 4;
  localparam int W  = 9;
  localparam int AW = 2;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst, start;
  logic busy, done, err, value, calculated, tb_we;
  logic [AW-1:0] addr_a, addr_b;
  logic [1:0] char_a, char_b;
  logic signed [W-1:0] diag, up, lx, max_in, final_score;
  logic [2:0] symbol_in, tb_sym;
  logic [TW-1:0] tb_addr;

  always #5 clk = ~clk;

  logic [1:0] seq_a [N];
  logic [1:0] seq_b [N];
  assign char_a = seq_a[addr_a];
  assign char_b = seq_b[addr_b];

  nw_fill_ctrl #(.N(N), .W(W), .MATCH(1), .MISMATCH(-1), .GAP(-2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .addr_a(addr_a), .addr_b(addr_b), .char_a(char_a), .char_b(char_b),
    .value(value), .diag(diag), .up(up), .lx(lx), .max_in(max_in),
    .symbol_in(symbol_in), .calculated(calculated), .tb_we(tb_we),
    .tb_addr(tb_addr), .tb_sym(tb_sym), .final_score(final_score)
  );

  // Behavioural Max: answers lat_cur cycles after value rises; ties favour diag, then up.
  int vcnt = 0;
  int lat_cur = 1;
  bit rand_lat = 1'b0;
  bit calc_en = 1'b1;

  always_ff @(posedge clk) begin
    if (!value) begin
      vcnt    <= 0;
      lat_cur <= rand_lat ? int'($urandom_range(1, 5)) : 1;
    end else begin
      vcnt <= vcnt + 1;
    end
  end

  assign calculated = calc_en && value && (vcnt >= lat_cur - 1);

  always_comb begin
    max_in    = diag;
    symbol_in = 3'b001;
    if (up > max_in) begin
      max_in    = up;
      symbol_in = 3'b010;
    end
    if (lx > max_in) begin
      max_in    = lx;
      symbol_in = 3'b100;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_total++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
  endtask

  int exp_d [N*N];
  int exp_u [N*N];
  int exp_l [N*N];
  int exp_s [N*N];
  int sym_run [N*N];
  int sym_ref [N*N];
  int first_d, first_u, first_l;

  task automatic build_model();
    int h [0:N][0:N];
    int k, d, u, l;
    for (int i = 0; i <= N; i++) begin
      h[i][0] = -2 * i;
      h[0][i] = -2 * i;
    end
    for (int i = 1; i <= N; i++) begin
      for (int j = 1; j <= N; j++) begin
        k = (i-1)*N + (j-1);
        d = h[i-1][j-1] + ((seq_a[i-1] == seq_b[j-1]) ? 1 : -1);
        u = h[i-1][j] - 2;
        l = h[i][j-1] - 2;
        exp_d[k] = d; exp_u[k] = u; exp_l[k] = l;
        h[i][j] = d; exp_s[k] = 1;
        if (u > h[i][j]) begin h[i][j] = u; exp_s[k] = 2; end
        if (l > h[i][j]) begin h[i][j] = l; exp_s[k] = 4; end
      end
    end
  endtask

  task automatic run_fill(input string nm, input bit rnd, input bit restart,
                          input int exp_final, input int exp_busy, input int exp_wr);
    int k, wr, dn, bcyc, c_rise, c_done, viol, post;
    bit fin_seen;
    logic pv, pc;
    logic signed [W-1:0] pd, pu, pl;
    k = 0; wr = 0; dn = 0; bcyc = 0; c_rise = -1; c_done = -1; viol = 0; post = 0;
    fin_seen = 1'b0; pv = 1'b0; pc = 1'b0; pd = '0; pu = '0; pl = '0;
    build_model();
    rand_lat = rnd;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      start = (restart && cyc == 20);
      if (busy) bcyc++;
      if (value && !pv) begin
        if (c_rise < 0) c_rise = cyc;
        if (k == 0) begin first_d = diag; first_u = up; first_l = lx; end
        if (k < N*N) begin
          check($sformatf("%s_diag%0d", nm, k), diag, exp_d[k]);
          check($sformatf("%s_up%0d", nm, k), up, exp_u[k]);
          check($sformatf("%s_lx%0d", nm, k), lx, exp_l[k]);
        end
        k++;
      end
      if (value && pv && (diag != pd || up != pu || lx != pl)) viol++;
      if (pv && !value && !pc) viol++;
      if (tb_we) begin
        if (wr < N*N) begin
          check($sformatf("%s_addr%0d", nm, wr), tb_addr, wr);
          check($sformatf("%s_sym%0d", nm, wr), tb_sym, exp_s[wr]);
          sym_run[wr] = tb_sym;
        end
        wr++;
      end
      if (done) begin
        dn++;
        if (!fin_seen) begin
          fin_seen = 1'b1;
          c_done = cyc;
          check({nm, "_busy_at_done"}, busy, 0);
        end
      end
      pv = value; pc = calculated; pd = diag; pu = up; pl = lx;
      if (fin_seen) post++;
      if (post > 3) break;
      @(negedge clk);
    end
    start = 1'b0;
    if (!fin_seen) check({nm, "_timeout"}, 0, 1);
    check({nm, "_final"}, final_score, exp_final);
    check({nm, "_writes"}, wr, exp_wr);
    check({nm, "_dones"}, dn, 1);
    check({nm, "_busy_end"}, busy, 0);
    check({nm, "_err"}, err, calc_en ? 0 : 1);
    check({nm, "_stable"}, viol, 0);
    if (exp_busy >= 0) check({nm, "_busy_cycles"}, bcyc, exp_busy);
`ifdef NW_WATCHDOG_EN
    if (!calc_en) check({nm, "_wd_latency"}, c_done - c_rise, 15);
`endif
  endtask

  int dn_cnt;
  bit got_val;

  initial begin
    rst = 1'b1; start = 1'b0;
    seq_a = '{2'd0, 2'd1, 2'd2, 2'd3};
    seq_b = '{2'd0, 2'd1, 2'd2, 2'd3};
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_value", value, 0);
    check("rst_tb_we", tb_we, 0);
    check("rst_final", final_score, 0);
    check("rst_diag", diag, 0);
    check("rst_tb_addr", tb_addr, 0);
    rst = 1'b0;

    // Reset asserted while waiting on Max.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    got_val = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (value) begin got_val = 1'b1; break; end
      @(negedge clk);
    end
    check("midrst_reached_wait", got_val, 1);
    rst = 1'b1;
    #1;
    check("midrst_value", value, 0);
    check("midrst_tb_we", tb_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk); rst = 1'b0;
    dn_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) dn_cnt++;
    end
    check("midrst_idle_busy", busy, 0);
    check("midrst_idle_value", value, 0);
    check("midrst_no_done", dn_cnt, 0);

    run_fill("acgt_lat1", 1'b0, 1'b0, 4, 56, 16);
    for (int i = 0; i < N*N; i++) sym_ref[i] = sym_run[i];

    run_fill("acgt_rnd", 1'b1, 1'b0, 4, -1, 16);
    for (int i = 0; i < N*N; i++) check($sformatf("rnd_same_sym%0d", i), sym_run[i], sym_ref[i]);

    run_fill("acgt_restart", 1'b0, 1'b1, 4, 56, 16);

    seq_a = '{2'd0, 2'd0, 2'd0, 2'd0};
    seq_b = '{2'd1, 2'd1, 2'd1, 2'd1};
    run_fill("aaaa_cccc", 1'b0, 1'b0, -4, 56, 16);
    check("cell11_diag", first_d, -1);
    check("cell11_up", first_u, -4);
    check("cell11_lx", first_l, -4);

`ifdef NW_WATCHDOG_EN
    calc_en = 1'b0;
    run_fill("watchdog", 1'b0, 1'b0, 0, -1, 0);
    calc_en = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
